interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer.sv | 112 +++++++++++
 tb/tb_interrupt_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: accepts an irq edge, drains the pipeline, pushes the return PC and jumps to VECTOR_ADDR.
// Optional INT_FLAG_SAVE_EN adds a third push carrying {carry, negative, zero} captured at drain exit.
module interrupt_sequencer #(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        irq_i,
    input  logic        ex_hold_i,
    input  logic        branch_taken_i,
    input  logic [31:0] new_pc_i,
    input  logic [31:0] pc_plus_one_i,
    input  logic [2:0]  flag_register_i,
    input  logic        mem_ready_i,
    output logic        stall_fetch_o,
    output logic        flush_decode_o,
    output logic        push_valid_o,
    output logic [15:0] push_data_o,
    output logic        pc_load_o,
    output logic [31:0] pc_load_value_o,
    output logic        int_active_o
);
`ifdef INT_FLAG_SAVE_EN
    typedef enum logic [2:0] {IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FLG, VECTOR} state_t;
    logic [2:0] flags_saved_q, flags_saved_d;
`else
    typedef enum logic [2:0] {IDLE, DRAIN, PUSH_HI, PUSH_LO, VECTOR} state_t;
    logic unused_flags;
    assign unused_flags = ^flag_register_i;
`endif
    state_t      state_q, state_d;
    logic        irq_q, pending_q, pending_d, accept;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] saved_pc_q, saved_pc_d;

    assign accept = (state_q == IDLE) && pending_q && !ex_hold_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            irq_q         <= 1'b1;
            pending_q     <= 1'b0;
            cnt_q         <= 4'd0;
            saved_pc_q    <= 32'd0;
`ifdef INT_FLAG_SAVE_EN
            flags_saved_q <= 3'd0;
`endif
        end else begin
            state_q       <= state_d;
            irq_q         <= irq_i;
            pending_q     <= pending_d;
            cnt_q         <= cnt_d;
            saved_pc_q    <= saved_pc_d;
`ifdef INT_FLAG_SAVE_EN
            flags_saved_q <= flags_saved_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        saved_pc_d = saved_pc_q;
`ifdef INT_FLAG_SAVE_EN
        flags_saved_d = flags_saved_q;
`endif
        // a new edge wins over the clear from acceptance in the same cycle
        pending_d  = (irq_i && !irq_q) || (pending_q && !accept);
        case (state_q)
            IDLE: if (accept) begin
                state_d    = DRAIN;
                cnt_d      = 4'(DRAIN_CYCLES);
                saved_pc_d = branch_taken_i ? new_pc_i : pc_plus_one_i;
            end
            DRAIN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = PUSH_HI;
`ifdef INT_FLAG_SAVE_EN
                    flags_saved_d = flag_register_i;
`endif
                end
            end
            PUSH_HI: if (mem_ready_i) state_d = PUSH_LO;
`ifdef INT_FLAG_SAVE_EN
            PUSH_LO:  if (mem_ready_i) state_d = PUSH_FLG;
            PUSH_FLG: if (mem_ready_i) state_d = VECTOR;
`else
            PUSH_LO: if (mem_ready_i) state_d = VECTOR;
`endif
            VECTOR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall_fetch_o   = state_q != IDLE;
    assign int_active_o    = state_q != IDLE;
    assign flush_decode_o  = state_q == DRAIN;
    assign pc_load_o       = state_q == VECTOR;
    assign pc_load_value_o = (state_q == VECTOR) ? VECTOR_ADDR : 32'd0;
`ifdef INT_FLAG_SAVE_EN
    assign push_valid_o = (state_q == PUSH_HI) || (state_q == PUSH_LO) || (state_q == PUSH_FLG);
    assign push_data_o  = (state_q == PUSH_HI)  ? saved_pc_q[31:16] :
                          (state_q == PUSH_LO)  ? saved_pc_q[15:0]  :
                          (state_q == PUSH_FLG) ? {13'd0, flags_saved_q} : 16'd0;
`else
    assign push_valid_o = (state_q == PUSH_HI) || (state_q == PUSH_LO);
    assign push_data_o  = (state_q == PUSH_HI) ? saved_pc_q[31:16] :
                          (state_q == PUSH_LO) ? saved_pc_q[15:0]  : 16'd0;
`endif
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed checks of the interrupt entry sequence with default parameters.
module tb_interrupt_sequencer;
    logic        clk = 1'b0;
    logic        reset, irq, ex_hold, branch_taken, mem_ready;
    logic [31:0] new_pc, pc_plus_one, pc_load_value;
    logic [2:0]  flag_register;
    logic        stall_fetch, flush_decode, push_valid, pc_load, int_active;
    logic [15:0] push_data;
    int          vectors = 0, miscompares = 0;

    localparam logic [4:0] O_IDLE = 5'b00000, O_DRAIN = 5'b11001, O_PUSH = 5'b10101, O_VEC = 5'b10011;

    interrupt_sequencer dut (
        .clk_i(clk), .reset_i(reset), .irq_i(irq), .ex_hold_i(ex_hold),
        .branch_taken_i(branch_taken), .new_pc_i(new_pc), .pc_plus_one_i(pc_plus_one),
        .flag_register_i(flag_register), .mem_ready_i(mem_ready),
        .stall_fetch_o(stall_fetch), .flush_decode_o(flush_decode), .push_valid_o(push_valid),
        .push_data_o(push_data), .pc_load_o(pc_load), .pc_load_value_o(pc_load_value),
        .int_active_o(int_active)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string tag, input logic [4:0] f, input logic [15:0] pd, input logic [31:0] plv);
        logic [52:0] obs, req;
        obs = {stall_fetch, flush_decode, push_valid, pc_load, int_active, push_data, pc_load_value};
        req = {f, pd, plv};
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    // irq low for one cycle then high; afterwards the FSM is IDLE with the request pending
    task automatic raise_irq(input string tag);
        irq = 1'b0;
        tick;
        irq = 1'b1;
        tick;
        expect_o({tag, "/pend"}, O_IDLE, 16'h0, 32'h0);
    endtask

    // full sequence from the acceptance cycle; execute-side inputs are scrambled to show they are ignored
    task automatic run_seq(input string tag, input logic [15:0] hi, input logic [15:0] lo, input logic [5:0] pat);
        logic        bt;
        logic [31:0] np, pp;
        bt = branch_taken; np = new_pc; pp = pc_plus_one;
        tick; expect_o({tag, "/d1"}, O_DRAIN, 16'h0, 32'h0); irq = pat[0];
        ex_hold = 1'b1; branch_taken = ~bt; new_pc = 32'hdead_beef; pc_plus_one = 32'hcafe_f00d;
        tick; expect_o({tag, "/d2"}, O_DRAIN, 16'h0, 32'h0); irq = pat[1];
        tick; expect_o({tag, "/d3"}, O_DRAIN, 16'h0, 32'h0); irq = pat[2];
        tick; expect_o({tag, "/hi"}, O_PUSH, hi, 32'h0);     irq = pat[3];
        tick; expect_o({tag, "/lo"}, O_PUSH, lo, 32'h0);     irq = pat[4];
`ifdef INT_FLAG_SAVE_EN
        tick; expect_o({tag, "/flg"}, O_PUSH, 16'h0005, 32'h0);
`endif
        tick; expect_o({tag, "/vec"}, O_VEC, 16'h0, 32'h0);  irq = pat[5];
        ex_hold = 1'b0; branch_taken = bt; new_pc = np; pc_plus_one = pp;
        tick; expect_o({tag, "/idle"}, O_IDLE, 16'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; irq = 1'b1; ex_hold = 1'b0; branch_taken = 1'b0; mem_ready = 1'b1;
        new_pc = 32'h0; pc_plus_one = 32'h0000_0124; flag_register = 3'b101;
        tick; tick;
        expect_o("reset", O_IDLE, 16'h0, 32'h0);
        reset = 1'b0;
        tick; expect_o("no_edge_after_reset1", O_IDLE, 16'h0, 32'h0);
        tick; expect_o("no_edge_after_reset2", O_IDLE, 16'h0, 32'h0);

        raise_irq("fallthru");
        run_seq("fallthru", 16'h0000, 16'h0124, 6'b111111);

        branch_taken = 1'b1; new_pc = 32'h0001_0040;
        raise_irq("branch");
        run_seq("branch", 16'h0001, 16'h0040, 6'b111111);
        branch_taken = 1'b0;

        raise_irq("memwait");
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin tick; expect_o("memwait/drain", O_DRAIN, 16'h0, 32'h0); end
        tick; expect_o("memwait/hi_enter", O_PUSH, 16'h0000, 32'h0);
        for (int i = 0; i < 4; i++) begin tick; expect_o("memwait/hi_hold", O_PUSH, 16'h0000, 32'h0); end
        mem_ready = 1'b1;
        tick; expect_o("memwait/lo", O_PUSH, 16'h0124, 32'h0);
        mem_ready = 1'b0;
        tick; expect_o("memwait/lo_hold", O_PUSH, 16'h0124, 32'h0);
        mem_ready = 1'b1;
`ifdef INT_FLAG_SAVE_EN
        tick; expect_o("memwait/flg", O_PUSH, 16'h0005, 32'h0);
`endif
        tick; expect_o("memwait/vec", O_VEC, 16'h0, 32'h0);
        tick; expect_o("memwait/idle", O_IDLE, 16'h0, 32'h0);

        raise_irq("edge_in_drain");
        run_seq("edge_in_drain", 16'h0000, 16'h0124, 6'b111110);
        run_seq("edge_in_drain_2nd", 16'h0000, 16'h0124, 6'b111111);
        tick; expect_o("edge_in_drain/quiet", O_IDLE, 16'h0, 32'h0);

        raise_irq("three_edges");
        run_seq("three_edges", 16'h0000, 16'h0124, 6'b101010);
        run_seq("three_edges_extra", 16'h0000, 16'h0124, 6'b111111);
        tick; expect_o("three_edges/quiet1", O_IDLE, 16'h0, 32'h0);
        tick; expect_o("three_edges/quiet2", O_IDLE, 16'h0, 32'h0);

        ex_hold = 1'b1;
        raise_irq("ex_hold");
        for (int i = 0; i < 5; i++) begin tick; expect_o("ex_hold/blocked", O_IDLE, 16'h0, 32'h0); end
        ex_hold = 1'b0;
        run_seq("ex_hold", 16'h0000, 16'h0124, 6'b111111);

        raise_irq("rst_mid");
        for (int i = 0; i < 3; i++) begin tick; expect_o("rst_mid/drain", O_DRAIN, 16'h0, 32'h0); end
        tick; expect_o("rst_mid/hi", O_PUSH, 16'h0000, 32'h0);
        tick; expect_o("rst_mid/lo", O_PUSH, 16'h0124, 32'h0);
        reset = 1'b1;
        tick; expect_o("rst_mid/abort", O_IDLE, 16'h0, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin tick; expect_o("rst_mid/irq_high_quiet", O_IDLE, 16'h0, 32'h0); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
